// File: rtl/keypad_scanner.sv
// Column-scanning front end for a 4x4 active-low matrix keypad.
// Drives one column low at a time, synchronizes the rows, and locks onto
// the first column that shows a pressed key until the key is released and
// the downstream debouncer has let go of scan_stop.
//
// state  | meaning
// DRIVE  | column col_idx driven, waiting SETTLE_CYCLES for rows to settle
// SAMPLE | one-cycle look at synchronized rows for the driven column
// LOCKED | column frozen, row snapshot tracked every cycle until release
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  input  logic       scan_stop,
  output logic [3:0] col_n,
  output logic       key_detected,
  output logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       multi_key
);

  typedef enum logic [1:0] {
    DRIVE  = 2'd0,
    SAMPLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] settle_cnt;
  logic [1:0] col_idx;
  logic [1:0] col_nxt;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] row_act;
  logic       row_multi;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  assign row_act   = ~sync2;
  // Clearing the lowest set bit leaves something only if two or more rows are active.
  assign row_multi = |(row_act & (row_act - 4'd1));
  assign col_nxt   = col_idx + 2'd1;

  // Two-flop synchronizer for the asynchronous row pins (idle = pulled up).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'b1111;
      sync2 <= 4'b1111;
    end else begin
      sync1 <= row_n;
      sync2 <= sync1;
    end
  end

  // Scan/lock state machine with registered column drive and key outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DRIVE;
      settle_cnt   <= 8'd0;
      col_idx      <= 2'd0;
      col_n        <= 4'b1110;
      key_detected <= 1'b0;
      key_row      <= 4'd0;
      key_col      <= 4'd0;
      multi_key    <= 1'b0;
    end else begin
      case (state)
        DRIVE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 8'd0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        SAMPLE: begin
          if (row_act != 4'd0) begin
            state        <= LOCKED;
            key_row      <= row_act;
            key_col      <= onehot(col_idx);
            key_detected <= 1'b1;
            multi_key    <= row_multi;
          end else begin
            col_idx <= col_nxt;
            col_n   <= ~onehot(col_nxt);
            state   <= DRIVE;
          end
        end
        LOCKED: begin
          key_row      <= row_act;
          key_detected <= |row_act;
          multi_key    <= row_multi;
          // Leave only once the keypad is quiet and the debouncer has released us.
          if (row_act == 4'd0 && !scan_stop) begin
            state      <= DRIVE;
            settle_cnt <= 8'd0;
            col_idx    <= col_nxt;
            col_n      <= ~onehot(col_nxt);
            key_col    <= 4'd0;
          end
        end
        default: begin
          state        <= DRIVE;
          settle_cnt   <= 8'd0;
          col_idx      <= 2'd0;
          col_n        <= 4'b1110;
          key_detected <= 1'b0;
          key_row      <= 4'd0;
          key_col      <= 4'd0;
          multi_key    <= 1'b0;
        end
      endcase
    end
  end

endmodule
